// File: rtl/reg_dump_if.sv
// Bus bundle between the register dump engine and its environment: read port 1
// of the register file, the freeze request/grant pair, and the dump output stream.
interface reg_dump_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic              grant;
  logic              req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W:0]   dump_idx;
  logic              dump_last;
  logic              busy;
  logic              done;

  // Dump engine side
  modport master (
    input  start, grant, rd_data, dump_ready,
    output req, rd_addr, dump_valid, dump_data, dump_idx, dump_last, busy, done
  );

  // Environment side: hazard control, register file and trace sink
  modport slave (
    output start, grant, rd_data, dump_ready,
    input  req, rd_addr, dump_valid, dump_data, dump_idx, dump_last, busy, done
  );
endinterface

// File: rtl/reg_dump_unit.sv
// Register file dump engine: on start, freezes the pipeline, walks r0..r(NUM_REGS-1)
// through read port 1 and streams each captured word over a valid/ready channel.
// Optional feature macro REG_DUMP_CHECKSUM_EN appends an XOR checksum word that
// carries dump_last; without it dump_last accompanies the final register.
module reg_dump_unit #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 1
) (
  input logic         clk,
  input logic         reset,
  reg_dump_if.master  bus
);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StReq, StAddr, StOut, StCsum, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StReq, StAddr, StOut, StDone} state_e;
`endif

  localparam logic [1:0]        LatLast = 2'(READ_LAT - 1);
  localparam logic [ADDR_W-1:0] IdxLast = ADDR_W'(NUM_REGS - 1);
`ifdef REG_DUMP_CHECKSUM_EN
  localparam logic [ADDR_W:0]   CsumIdx = (ADDR_W + 1)'(NUM_REGS);
`endif

  state_e            state;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lat_cnt;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  // Sequencer: all outputs are registered and updated on the transition into
  // the state that owns them, so they are glitch-free toward the ID stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= StIdle;
      idx            <= '0;
      lat_cnt        <= '0;
      bus.req        <= 1'b0;
      bus.rd_addr    <= '0;
      bus.dump_valid <= 1'b0;
      bus.dump_data  <= '0;
      bus.dump_idx   <= '0;
      bus.dump_last  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      checksum       <= '0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.start) begin
            state    <= StReq;
            idx      <= '0;
            bus.req  <= 1'b1;
            bus.busy <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
            checksum <= '0;
`endif
          end
        end
        StReq: begin
          if (bus.grant) begin
            state       <= StAddr;
            lat_cnt     <= '0;
            bus.rd_addr <= idx;
          end
        end
        StAddr: begin
          // Losing the grant invalidates any partial wait on the read port.
          if (!bus.grant) begin
            lat_cnt <= '0;
          end else if (lat_cnt == LatLast) begin
            state          <= StOut;
            lat_cnt        <= '0;
            bus.dump_valid <= 1'b1;
            bus.dump_data  <= bus.rd_data;
            bus.dump_idx   <= {1'b0, idx};
`ifdef REG_DUMP_CHECKSUM_EN
            bus.dump_last  <= 1'b0;
            checksum       <= checksum ^ bus.rd_data;
`else
            bus.dump_last  <= (idx == IdxLast);
`endif
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        StOut: begin
          if (bus.dump_ready) begin
            if (idx != IdxLast) begin
              state          <= StAddr;
              idx            <= idx + ADDR_W'(1);
              bus.rd_addr    <= idx + ADDR_W'(1);
              bus.dump_valid <= 1'b0;
              bus.dump_last  <= 1'b0;
            end else begin
`ifdef REG_DUMP_CHECKSUM_EN
              state          <= StCsum;
              bus.dump_valid <= 1'b1;
              bus.dump_idx   <= CsumIdx;
              bus.dump_data  <= checksum;
              bus.dump_last  <= 1'b1;
`else
              state          <= StDone;
              bus.dump_valid <= 1'b0;
              bus.dump_last  <= 1'b0;
              bus.req        <= 1'b0;
              bus.done       <= 1'b1;
`endif
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        StCsum: begin
          if (bus.dump_ready) begin
            state          <= StDone;
            bus.dump_valid <= 1'b0;
            bus.dump_last  <= 1'b0;
            bus.req        <= 1'b0;
            bus.done       <= 1'b1;
          end
        end
`endif
        StDone: begin
          // start is deliberately not looked at here
          state         <= StIdle;
          bus.busy      <= 1'b0;
          bus.done      <= 1'b0;
          bus.dump_data <= '0;
          bus.dump_idx  <= '0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Bench for reg_dump_unit: a vector table for reset/handshake basics, then full
// dumps on a READ_LAT=1 and a READ_LAT=2 instance checked against an expected
// word stream derived from the register file contents.
module tb_reg_dump_unit;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, grant, ready, sel;

  reg_dump_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();
  reg_dump_if #(.ADDR_W(AW), .DATA_W(DW)) if2 ();

  assign if1.start      = start & ~sel;
  assign if2.start      = start & sel;
  assign if1.grant      = grant;
  assign if2.grant      = grant;
  assign if1.dump_ready = ready;
  assign if2.dump_ready = ready;

  // Register file model: combinational read for latency 1, one flop for latency 2
  logic [DW-1:0] mem [NR];
  logic [DW-1:0] rd2_q;
  assign if1.rd_data = mem[if1.rd_addr];
  always @(posedge clk) rd2_q <= mem[if2.rd_addr];
  assign if2.rd_data = rd2_q;

  reg_dump_unit #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.master)
  );
  reg_dump_unit #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2.master)
  );

  typedef struct packed {
    logic          req;
    logic          busy;
    logic          done;
    logic          valid;
    logic          last;
    logic [AW:0]   idx;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } obs_t;

  obs_t cur;
  always_comb begin
    if (sel) cur = {if2.req, if2.busy, if2.done, if2.dump_valid, if2.dump_last,
                    if2.dump_idx, if2.dump_data, if2.rd_addr};
    else     cur = {if1.req, if1.busy, if1.done, if1.dump_valid, if1.dump_last,
                    if1.dump_idx, if1.dump_data, if1.rd_addr};
  end

  typedef struct {
    logic          rst, st, gr, rdy;
    logic          req, busy, valid;
    logic [AW:0]   idx;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } vec_t;

  typedef struct packed {
    logic [AW:0]   idx;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  word_t expq[$];
  int    done_cnt, busy_cnt, stall_n;
  bit    mon_en;
  bit    hold_v;
  obs_t  hold;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic rst, logic st, logic gr, logic rdy, logic req, logic busy,
                              logic valid, logic [AW:0] idx, logic [DW-1:0] data,
                              logic [AW-1:0] addr);
    vec_t v;
    v.rst = rst; v.st = st; v.gr = gr; v.rdy = rdy;
    v.req = req; v.busy = busy; v.valid = valid;
    v.idx = idx; v.data = data; v.addr = addr;
    return v;
  endfunction

  // Expected stream: every register in order, then the XOR word when enabled
  task automatic build_expect();
    logic [DW-1:0] x;
    word_t w;
    x = '0;
    expq.delete();
    for (int i = 0; i < NR; i++) begin
      x = x ^ mem[i];
      w.idx  = (AW + 1)'(i);
      w.data = mem[i];
      w.last = (CS == 0) && (i == NR - 1);
      expq.push_back(w);
    end
    if (CS != 0) begin
      w.idx  = (AW + 1)'(NR);
      w.data = x;
      w.last = 1'b1;
      expq.push_back(w);
    end
  endtask

  // Called with outputs from the last edge and inputs set for the next edge
  task automatic monitor();
    word_t w;
    if (cur.busy) busy_cnt++;
    if (cur.done) done_cnt++;
    if (hold_v)
      chk("stall_hold", 64'({cur.valid, cur.idx, cur.data}), 64'({1'b1, hold.idx, hold.data}));
    hold_v = cur.valid && !ready;
    hold   = cur;
    if (cur.valid && ready) begin
      if (expq.size() == 0) begin
        chk("extra_word", 64'({cur.idx, cur.data}), 64'(0));
        if ({cur.idx, cur.data} == '0) chk("extra_word_seen", 64'd0, 64'd1);
      end else begin
        w = expq.pop_front();
        chk("word", 64'({cur.idx, cur.data, cur.last}), 64'({w.idx, w.data, w.last}));
      end
    end
  endtask

  task automatic cyc();
    if (mon_en) monitor();
    @(negedge clk);
  endtask

  task automatic start_dump(input bit s);
    sel = s;
    build_expect();
    done_cnt = 0; busy_cnt = 0; stall_n = 0; hold_v = 1'b0;
    grant = 1'b1; ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic finish_dump(input int budget, input bit rnd, input int stall_idx,
                             input int exp_busy);
    int n;
    n = 0;
    while (!cur.done && n < budget) begin
      if (rnd) begin
        grant = ($urandom_range(0, 3) != 0);
        ready = ($urandom_range(0, 2) != 0);
      end else begin
        grant = 1'b1;
        ready = 1'b1;
      end
      if (cur.valid && int'(cur.idx) == stall_idx && stall_n < 5) begin
        ready = 1'b0;
        stall_n++;
      end
      cyc();
      n++;
    end
    if (!cur.done) begin
      chk("dump_timeout", 64'd0, 64'd1);
    end else begin
      start = 1'b1;                     // coincident with DONE, must be ignored
      cyc();
      start = 1'b0;
      chk("busy_after_done", 64'(cur.busy), 64'd0);
      cyc();
      chk("start_at_done_ignored", 64'({cur.busy, cur.req}), 64'd0);
      chk("done_once", 64'(done_cnt), 64'd1);
      chk("queue_drained", 64'(expq.size()), 64'd0);
      if (exp_busy >= 0) chk("dump_cycles", 64'(busy_cnt), 64'(exp_busy));
    end
  endtask

  vec_t tbl[13];

  initial begin
    obs_t e;
    int   n;

    // r0 = 0, others carry their index in the low bits
    for (int i = 0; i < NR; i++) mem[i] = (i == 0) ? '0 : 32'hA5A50000 + DW'(i);

    //            rst st gr rdy  req busy vld idx  data           addr
    tbl[0]  = mk(1, 0, 0, 0,    0, 0, 0,  6'd0, 32'h0,         5'd0);
    tbl[1]  = mk(1, 1, 1, 1,    0, 0, 0,  6'd0, 32'h0,         5'd0);
    tbl[2]  = mk(0, 0, 0, 0,    0, 0, 0,  6'd0, 32'h0,         5'd0);
    tbl[3]  = mk(0, 1, 0, 0,    1, 1, 0,  6'd0, 32'h0,         5'd0);
    tbl[4]  = mk(0, 0, 0, 0,    1, 1, 0,  6'd0, 32'h0,         5'd0);
    tbl[5]  = mk(0, 0, 1, 0,    1, 1, 0,  6'd0, 32'h0,         5'd0);
    tbl[6]  = mk(0, 0, 1, 0,    1, 1, 1,  6'd0, 32'h0,         5'd0);
    tbl[7]  = mk(0, 0, 0, 0,    1, 1, 1,  6'd0, 32'h0,         5'd0);
    tbl[8]  = mk(0, 0, 0, 1,    1, 1, 0,  6'd0, 32'h0,         5'd1);
    tbl[9]  = mk(0, 0, 0, 1,    1, 1, 0,  6'd0, 32'h0,         5'd1);
    tbl[10] = mk(0, 0, 1, 0,    1, 1, 1,  6'd1, 32'hA5A50001,  5'd1);
    tbl[11] = mk(1, 0, 1, 1,    0, 0, 0,  6'd0, 32'h0,         5'd0);
    tbl[12] = mk(0, 0, 0, 0,    0, 0, 0,  6'd0, 32'h0,         5'd0);

    reset = 1'b1; start = 1'b0; grant = 1'b0; ready = 1'b0; sel = 1'b0;
    mon_en = 1'b0; hold_v = 1'b0; done_cnt = 0; busy_cnt = 0; stall_n = 0;
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      reset = tbl[i].rst; start = tbl[i].st; grant = tbl[i].gr; ready = tbl[i].rdy;
      @(negedge clk);
      e = {tbl[i].req, tbl[i].busy, 1'b0, tbl[i].valid, 1'b0, tbl[i].idx, tbl[i].data,
           tbl[i].addr};
      chk($sformatf("vec%0d", i), 64'(cur), 64'(e));
    end
    start = 1'b0; reset = 1'b0;

    // Idle for 10 cycles: everything quiet on both instances
    mon_en = 1'b1;
    expq.delete();
    grant = 1'b0; ready = 1'b0;
    repeat (10) cyc();
    chk("idle_outputs_l1", 64'({if1.req, if1.busy, if1.done, if1.dump_valid, if1.dump_last,
                                if1.dump_idx, if1.dump_data, if1.rd_addr}), 64'd0);
    chk("idle_outputs_l2", 64'({if2.req, if2.busy, if2.done, if2.dump_valid, if2.dump_last,
                                if2.dump_idx, if2.dump_data}), 64'd0);

    // Clean dump, latency 1: two cycles per word
    start_dump(1'b0);
    finish_dump(500, 1'b0, -1, 1 + NR * 2 + CS + 1);

    // Back-pressure on idx 7 for 5 cycles
    start_dump(1'b0);
    finish_dump(500, 1'b0, 7, 1 + NR * 2 + CS + 1 + 5);
    chk("stall_applied", 64'(stall_n), 64'd5);

    // Reset while idx 20 is on the output, then restart from scratch
    start_dump(1'b0);
    n = 0;
    while (!(cur.valid && cur.idx == 6'd20) && n < 200) begin
      cyc();
      n++;
    end
    chk("reached_idx20", 64'({cur.valid, cur.idx}), 64'({1'b1, 6'd20}));
    ready = 1'b0; reset = 1'b1;
    cyc();
    hold_v = 1'b0;
    chk("reset_mid_outputs", 64'(cur), 64'd0);
    reset = 1'b0;
    cyc();
    chk("no_done_on_abort", 64'(done_cnt), 64'd0);
    start_dump(1'b0);
    finish_dump(500, 1'b0, -1, 1 + NR * 2 + CS + 1);

    // Latency 2 with grant dropped for 3 cycles during the read of r12
    start_dump(1'b1);
    n = 0;
    while (cur.addr != 5'd12 && n < 200) begin
      cyc();
      n++;
    end
    chk("reached_addr12", 64'({cur.addr, cur.valid}), 64'({5'd12, 1'b0}));
    grant = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("gdrop_hold%0d", k), 64'({cur.addr, cur.valid, cur.req}),
          64'({5'd12, 1'b0, 1'b1}));
    end
    grant = 1'b1;
    cyc();
    chk("gdrop_wait1", 64'({cur.addr, cur.valid}), 64'({5'd12, 1'b0}));
    cyc();
    chk("gdrop_capture", 64'({cur.valid, cur.idx, cur.data}), 64'({1'b1, 6'd12, mem[12]}));
    finish_dump(500, 1'b0, -1, 1 + NR * 3 + CS + 1 + 3);

    // Random register contents with random grant and back-pressure on both latencies
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NR; i++) mem[i] = (i == 0) ? '0 : DW'($urandom);
      start_dump(r[0]);
      finish_dump(3000, 1'b1, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case a wait above is ever left unbounded
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
